// File: rtl/captura_gray_antirrebote.sv
// -----------------------------------------------------------------------------
// captura_gray_antirrebote
//
// Captures a 4-bit Gray code from asynchronous, bouncy board switches. The
// word is synchronised into the clk domain, debounced as a whole, and
// converted to binary for the downstream display_7segmentos block. Commits
// that change more than one bit relative to the previous committed word are
// flagged, because a legal Gray step only ever flips one bit.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable clk cycles required before a commit
//                    (>= 1; 1000000 gives 10 ms at 100 MHz).
//
// Ports:
//   clk             system clock (100 MHz)
//   reset           asynchronous reset, active low (0 = in reset)
//   gray_in[3:0]    raw switch Gray code, asynchronous to clk
//   gray_q[3:0]     last committed (debounced) Gray word
//   bin[3:0]        binary equivalent of gray_q
//   nuevo           one-cycle pulse on the cycle gray_q/bin update
//   salto_invalido  one-cycle pulse with nuevo when the commit differs from
//                   the previous gray_q in more than one bit
// -----------------------------------------------------------------------------
module captura_gray_antirrebote #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] gray_in,
  output logic [3:0] gray_q,
  output logic [3:0] bin,
  output logic       nuevo,
  output logic       salto_invalido
);

  // Counter is one bit wider than strictly needed so that the terminal
  // value DEBOUNCE_CYCLES-1 always fits, including the degenerate N=1 case.
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  // True when more than one bit is set: clearing the lowest set bit
  // (d & (d-1)) leaves something only if a second bit was set.
  function automatic logic multi_bit(input logic [3:0] d);
    return ((d & (d - 4'd1)) != 4'd0);
  endfunction

  logic [3:0]       s1_q;
  logic [3:0]       s2_q;
  logic [3:0]       cand_q,     cand_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [3:0]       gray_com_q, gray_com_d;
  logic [3:0]       bin_q,      bin_d;
  logic             nuevo_q,    nuevo_d;
  logic             salto_q,    salto_d;
  logic             primero_q,  primero_d;

  // Two-flop synchroniser; only s2_q is used downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 4'b0000;
      s2_q <= 4'b0000;
    end else begin
      s1_q <= gray_in;
      s2_q <= s1_q;
    end
  end

  // Debounce/commit next-state logic.
  always_comb begin
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    gray_com_d = gray_com_q;
    bin_d      = bin_q;
    nuevo_d    = 1'b0;
    salto_d    = 1'b0;
    primero_d  = primero_q;

    if (s2_q != cand_q) begin
      // Any movement of the synchronised input restarts the stability count.
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      // Saturated: commit only if the stable word is actually new. A glitch
      // that settles back on the committed value lands here with no effect.
      if (cand_q != gray_com_q) begin
        gray_com_d = cand_q;
        bin_d      = gray2bin(cand_q);
        nuevo_d    = 1'b1;
        // Power-up switch position is arbitrary, so the first commit is
        // never treated as a jump.
        salto_d    = multi_bit(cand_q ^ gray_com_q) && !primero_q;
        primero_d  = 1'b0;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Debounce, committed-word and pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_q     <= 4'b0000;
      cnt_q      <= '0;
      gray_com_q <= 4'b0000;
      bin_q      <= 4'b0000;
      nuevo_q    <= 1'b0;
      salto_q    <= 1'b0;
      primero_q  <= 1'b1;
    end else begin
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      gray_com_q <= gray_com_d;
      bin_q      <= bin_d;
      nuevo_q    <= nuevo_d;
      salto_q    <= salto_d;
      primero_q  <= primero_d;
    end
  end

  assign gray_q         = gray_com_q;
  assign bin            = bin_q;
  assign nuevo          = nuevo_q;
  assign salto_invalido = salto_q;

endmodule
